// File: rtl/core_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer: owns pc, the fetch handshake, write-back gating and redirects.
// Latency: (1 + memory wait) FETCH cycles + 3 cycles per instruction; 4 cycles with a zero-wait memory.
// Backpressure: stalls in FETCH until imem_rvalid, and traps to ERR after FETCH_TIMEOUT cycles without data.
module core_seq #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic        branch,
    input  logic        jump,
    input  logic        reg_wen_dec,
    input  logic        alu_zero,
    input  logic [31:0] target,
    output logic        reg_wen,
    output logic        retire,
    output logic [31:0] instret,
    output logic        busy,
    output logic        err,
    output logic [1:0]  err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_ERR
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  tcnt;
    logic        taken;
    logic [31:0] target_q;
    logic        halt_req;

    // Redirect decision made while the decoder/ALU outputs are settled in EXEC.
    logic exec_taken;
    logic exec_misalign;
    logic tcnt_last;

    assign exec_taken    = jump | (branch & ~alu_zero);
    assign exec_misalign = exec_taken & (target[1:0] != 2'b00);
    assign tcnt_last     = (tcnt == 8'(FETCH_TIMEOUT - 1));

    // Moore outputs decoded from the state register only; write strobe gated to WB.
    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;
    assign busy      = (state != S_IDLE);
    assign err       = (state == S_ERR);
    assign retire    = (state == S_WB);
    assign reg_wen   = (state == S_WB) & reg_wen_dec;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; rvalid in the last allowed FETCH cycle beats the timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (run) state_nxt = S_FETCH;
            S_FETCH: begin
                if (imem_rvalid)    state_nxt = S_DECODE;
                else if (tcnt_last) state_nxt = S_ERR;
            end
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC:   state_nxt = exec_misalign ? S_ERR : S_WB;
            S_WB:     state_nxt = (run & ~halt_req & ~halt) ? S_FETCH : S_IDLE;
            S_ERR:    state_nxt = S_ERR;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Instruction latch, fetch timer, redirect capture, pc/instret update and error code.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            inst     <= 32'h0;
            instret  <= 32'h0;
            tcnt     <= 8'h0;
            taken    <= 1'b0;
            target_q <= 32'h0;
            err_code <= 2'b00;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_rvalid) begin
                        inst <= imem_rdata;
                        tcnt <= 8'h0;
                    end else if (tcnt_last) begin
                        err_code <= 2'b01;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                S_EXEC: begin
                    taken    <= exec_taken;
                    target_q <= target;
                    if (exec_misalign) err_code <= 2'b10;
                end
                S_WB: begin
                    pc      <= taken ? target_q : pc + 32'd4;
                    instret <= instret + 32'd1;
                end
                default: ;
            endcase
        end
    end

    // Stop request: latched outside IDLE, consumed at WB, dropped once idle.
    always_ff @(posedge clk) begin
        if (rst)                  halt_req <= 1'b0;
        else if (state == S_IDLE) halt_req <= 1'b0;
        else if (halt)            halt_req <= 1'b1;
    end

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq with FETCH_TIMEOUT=8 and a hand-driven instruction memory.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
// Expected pc/instret are tracked by the bench from the directed vectors.
module tb_core_seq;

    logic        clk = 1'b0;
    logic        rst, run, halt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst, pc;
    logic        branch, jump, reg_wen_dec, alu_zero;
    logic [31:0] target;
    logic        reg_wen, retire;
    logic [31:0] instret;
    logic        busy, err;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_instret;

    core_seq #(.RESET_PC(32'h0), .FETCH_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .run(run), .halt(halt),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst(inst), .pc(pc),
        .branch(branch), .jump(jump), .reg_wen_dec(reg_wen_dec),
        .alu_zero(alu_zero), .target(target),
        .reg_wen(reg_wen), .retire(retire), .instret(instret),
        .busy(busy), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset for two edges, check reset values, release in IDLE.
    task automatic do_reset();
        rst = 1'b1;
        imem_rvalid = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_pc", pc, 0);
        chk("rst_inst", inst, 0);
        chk("rst_instret", instret, 0);
        chk("rst_err", {err, err_code}, 0);
        chk("rst_strobes", {imem_req, reg_wen, retire}, 0);
        rst = 1'b0;
        exp_pc = 32'h0;
        exp_instret = 32'h0;
    endtask

    // One instruction, entered at the first FETCH cycle.
    task automatic do_instr(input int wt, input logic [31:0] word,
                            input logic b, input logic j, input logic wd,
                            input logic z, input logic [31:0] tgt,
                            input logic [31:0] next_pc, input logic halt_exec);
        branch = b; jump = j; reg_wen_dec = wd; alu_zero = z; target = tgt;
        imem_rdata = word;
        for (int k = 0; k <= wt; k++) begin
            chk("fetch_req", imem_req, 1);
            chk("fetch_addr", imem_addr, exp_pc);
            chk("fetch_retire", retire, 0);
            imem_rvalid = (k == wt);
            tick();
        end
        imem_rvalid = 1'b0;
        chk("dec_inst", inst, word);
        chk("dec_strobes", {imem_req, reg_wen, retire}, 0);
        tick();
        chk("exec_strobes", {imem_req, reg_wen, retire}, 0);
        halt = halt_exec;
        tick();
        halt = 1'b0;
        chk("wb_retire", retire, 1);
        chk("wb_reg_wen", reg_wen, wd);
        chk("wb_pc_stable", pc, exp_pc);
        tick();
        exp_pc = next_pc;
        exp_instret = exp_instret + 1;
        chk("post_pc", pc, exp_pc);
        chk("post_instret", instret, exp_instret);
        chk("post_retire", retire, 0);
        if (halt_exec) begin
            chk("halt_idle_busy", busy, 0);
            chk("halt_idle_req", imem_req, 0);
            tick();
        end
        chk("next_fetch_req", imem_req, 1);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; halt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        branch = 1'b0; jump = 1'b0; reg_wen_dec = 1'b0; alu_zero = 1'b0; target = 32'h0;
        exp_pc = 32'h0; exp_instret = 32'h0;

        do_reset();
        chk("idle_run0_req", imem_req, 0);
        tick();
        chk("idle_stays", busy, 0);
        run = 1'b1;
        tick();
        // addi, zero wait: pc 0 -> 4
        do_instr(0, 32'h0010_0093, 0, 0, 1, 0, 32'h0, 32'h4, 0);
        // bne taken -> 0x40
        do_instr(0, 32'h0000_1463, 1, 0, 0, 0, 32'h40, 32'h40, 0);
        // bne not taken -> 0x44
        do_instr(0, 32'h0000_1463, 1, 0, 0, 1, 32'h48, 32'h44, 0);
        // jal -> 0x100 with write
        do_instr(0, 32'h0000_00ef, 0, 1, 1, 0, 32'h100, 32'h100, 0);
        // memory wait 3: 4 fetch cycles
        do_instr(3, 32'h0010_0093, 0, 0, 1, 0, 32'h0, 32'h104, 0);
        // rvalid in the 8th fetch cycle wins over the timeout
        do_instr(7, 32'h0000_0013, 0, 0, 0, 0, 32'h0, 32'h108, 0);
        chk("late_rvalid_noerr", {err, err_code}, 0);
        // halt in EXEC: retire, then IDLE, then restart since run=1
        do_instr(0, 32'h0000_0013, 0, 0, 0, 0, 32'h0, 32'h10c, 1);
        // inst 0 retires as a NOP
        do_instr(0, 32'h0000_0000, 0, 0, 0, 0, 32'h0, 32'h110, 0);

        // reset mid-FETCH with rvalid present
        rst = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hdead_beef;
        tick();
        imem_rvalid = 1'b0;
        chk("rstf_busy", busy, 0);
        chk("rstf_pc", pc, 0);
        chk("rstf_inst", inst, 0);
        chk("rstf_instret", instret, 0);
        rst = 1'b0;
        exp_pc = 32'h0; exp_instret = 32'h0;
        tick();
        chk("rstf_refetch_addr", imem_addr, 0);

        // misaligned taken branch from pc 0
        do_instr(0, 32'h0010_0093, 0, 0, 1, 0, 32'h0, 32'h4, 0);
        branch = 1'b1; jump = 1'b0; alu_zero = 1'b0; target = 32'h42; reg_wen_dec = 1'b1;
        imem_rdata = 32'h0000_1463;
        imem_rvalid = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        tick();
        tick();
        chk("mis_err", err, 1);
        chk("mis_code", err_code, 2'b10);
        chk("mis_strobes", {imem_req, reg_wen, retire}, 0);
        chk("mis_pc", pc, 32'h4);
        chk("mis_instret", instret, 1);
        tick();
        tick();
        chk("mis_sticky", {err, err_code, busy, retire}, {1'b1, 2'b10, 1'b1, 1'b0});

        // fetch timeout with FETCH_TIMEOUT=8
        do_reset();
        tick();
        for (int k = 0; k < 8; k++) begin
            chk("to_req", imem_req, 1);
            tick();
        end
        chk("to_err", err, 1);
        chk("to_code", err_code, 2'b01);
        chk("to_req_low", imem_req, 0);
        imem_rvalid = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick();
        imem_rvalid = 1'b0;
        tick();
        chk("to_ignore_inst", inst, 0);
        chk("to_still_err", {err, err_code, imem_req, retire}, {1'b1, 2'b01, 1'b0, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
